// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation codes,
// FSM states and default latencies.
package muldiv_unit_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned OP_W  = 4;

  localparam int unsigned DEF_MULT_LAT = 5;
  localparam int unsigned DEF_DIV_LAT  = 10;

  localparam logic [OP_W-1:0] MULOP_NONE  = 4'd0;
  localparam logic [OP_W-1:0] MULOP_MULT  = 4'd1;
  localparam logic [OP_W-1:0] MULOP_MULTU = 4'd2;
  localparam logic [OP_W-1:0] MULOP_DIV   = 4'd3;
  localparam logic [OP_W-1:0] MULOP_DIVU  = 4'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_divcore.sv
// Combinational signed/unsigned 32-bit divider: quotient truncates toward zero,
// remainder takes the sign of the dividend.
module muldiv_divcore
  import muldiv_unit_pkg::*;
(
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            signed_i,
  output logic [XLEN-1:0] quot_o,
  output logic [XLEN-1:0] rem_o
);

  logic            neg_a;
  logic            neg_b;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic [XLEN-1:0] div_b;
  logic [XLEN-1:0] uquot;
  logic [XLEN-1:0] urem;

  // Divide magnitudes, then restore signs; a zero divisor is forced to 1 so the
  // datapath never produces X (the caller discards the result in that case).
  assign neg_a = signed_i & a_i[XLEN-1];
  assign neg_b = signed_i & b_i[XLEN-1];
  assign mag_a = neg_a ? (~a_i + XLEN'(1)) : a_i;
  assign mag_b = neg_b ? (~b_i + XLEN'(1)) : b_i;
  assign div_b = (mag_b == '0) ? XLEN'(1) : mag_b;
  assign uquot = mag_a / div_b;
  assign urem  = mag_a % div_b;

  assign quot_o = (neg_a ^ neg_b) ? (~uquot + XLEN'(1)) : uquot;
  assign rem_o  = neg_a ? (~urem + XLEN'(1)) : urem;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle HI/LO multiply/divide unit with mthi/mtlo writes and a decode
// stall output.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned MULT_LAT = DEF_MULT_LAT,
  parameter int unsigned DIV_LAT  = DEF_DIV_LAT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [OP_W-1:0] mulop,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            whi,
  input  logic            wlo,
  input  logic [XLEN-1:0] wdata,
  input  logic            hazmulti,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            stall
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [XLEN-1:0]    hi_q, hi_d;
  logic [XLEN-1:0]    lo_q, lo_d;
  logic [XLEN-1:0]    opa_q, opa_d;
  logic [XLEN-1:0]    opb_q, opb_d;
  logic               sgn_q, sgn_d;

  logic [2*XLEN-1:0]  ext_a;
  logic [2*XLEN-1:0]  ext_b;
  logic [2*XLEN-1:0]  prod;
  logic [XLEN-1:0]    quot;
  logic [XLEN-1:0]    rem;

  // Sign-extend to 64 bits; the low 64 bits of the product are exact either way.
  assign ext_a = {{XLEN{sgn_q & opa_q[XLEN-1]}}, opa_q};
  assign ext_b = {{XLEN{sgn_q & opb_q[XLEN-1]}}, opb_q};
  assign prod  = ext_a * ext_b;

  muldiv_divcore u_divcore (
    .a_i      (opa_q),
    .b_i      (opb_q),
    .signed_i (sgn_q),
    .quot_o   (quot),
    .rem_o    (rem)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sgn_d   = sgn_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (mulop)
            MULOP_MULT, MULOP_MULTU: begin
              state_d = ST_MUL;
              cnt_d   = CNT_W'(MULT_LAT);
              busy_d  = 1'b1;
              opa_d   = a;
              opb_d   = b;
              sgn_d   = (mulop == MULOP_MULT);
            end
            MULOP_DIV, MULOP_DIVU: begin
              state_d = ST_DIV;
              cnt_d   = CNT_W'(DIV_LAT);
              busy_d  = 1'b1;
              opa_d   = a;
              opb_d   = b;
              sgn_d   = (mulop == MULOP_DIV);
            end
            default: ;
          endcase
        end else begin
          if (whi) hi_d = wdata;
          if (wlo) lo_d = wdata;
        end
      end
      ST_MUL, ST_DIV: begin
        // Last busy cycle: commit on this edge and drop back to idle.
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          if (state_q == ST_MUL) begin
            hi_d = prod[2*XLEN-1:XLEN];
            lo_d = prod[XLEN-1:0];
          end else if (opb_q != '0) begin
            hi_d = rem;
            lo_d = quot;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      sgn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sgn_q   <= sgn_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = busy_q;
  assign stall = hazmulti & (busy_q | start);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a result-queue model checked every cycle plus
// literal expectations for the key operations.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int unsigned ML = 5;
  localparam int unsigned DL = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  mulop = 4'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        whi = 1'b0;
  logic        wlo = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic        hazmulti = 1'b0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mulop    (mulop),
    .a        (a),
    .b        (b),
    .whi      (whi),
    .wlo      (wlo),
    .wdata    (wdata),
    .hazmulti (hazmulti),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .stall    (stall)
  );

  always #5 clk = ~clk;

  // Model: compute the answer when the op is accepted, release it after the latency.
  logic [31:0]     m_hi = 32'd0;
  logic [31:0]     m_lo = 32'd0;
  logic [31:0]     r_hi = 32'd0;
  logic [31:0]     r_lo = 32'd0;
  int              m_left = 0;
  bit              m_commit = 1'b0;
  longint          sp, sq, sr;
  longint unsigned up;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi = 32'd0; m_lo = 32'd0; m_left = 0; m_commit = 1'b0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0 && m_commit) begin
        m_hi = r_hi; m_lo = r_lo;
      end
    end else if (start) begin
      case (mulop)
        4'd1: begin
          sp = longint'($signed(a)) * longint'($signed(b));
          r_hi = sp[63:32]; r_lo = sp[31:0]; m_left = ML; m_commit = 1'b1;
        end
        4'd2: begin
          up = {32'd0, a} * {32'd0, b};
          r_hi = up[63:32]; r_lo = up[31:0]; m_left = ML; m_commit = 1'b1;
        end
        4'd3: begin
          m_left = DL; m_commit = (b != 32'd0);
          if (b != 32'd0) begin
            sq = longint'($signed(a)) / longint'($signed(b));
            sr = longint'($signed(a)) % longint'($signed(b));
            r_lo = sq[31:0]; r_hi = sr[31:0];
          end
        end
        4'd4: begin
          m_left = DL; m_commit = (b != 32'd0);
          if (b != 32'd0) begin
            r_lo = a / b; r_hi = a % b;
          end
        end
        default: ;
      endcase
    end else begin
      if (whi) m_hi = wdata;
      if (wlo) m_lo = wdata;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cyc_hi", 64'(hi), 64'(m_hi));
    chk("cyc_lo", 64'(lo), 64'(m_lo));
    chk("cyc_busy", 64'(busy), 64'(m_left != 0));
    chk("cyc_stall", 64'(stall), 64'(hazmulti && (m_left != 0 || start)));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; mulop = op; a = x; b = y;
    cyc();
    start = 1'b0; mulop = 4'd0;
  endtask

  task automatic mt(input logic h, input logic l, input logic [31:0] d);
    whi = h; wlo = l; wdata = d;
    cyc();
    whi = 1'b0; wlo = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int exp);
    int n;
    n = 0;
    while (busy && n < 40) begin
      n++;
      cyc();
    end
    chk(nm, 64'(n), 64'(exp));
  endtask

  task automatic pin(input string nm, input logic [31:0] eh, input logic [31:0] el);
    chk({nm, "_hi"}, 64'(hi), 64'(eh));
    chk({nm, "_lo"}, 64'(lo), 64'(el));
    chk({nm, "_model_hi"}, 64'(m_hi), 64'(eh));
    chk({nm, "_model_lo"}, 64'(m_lo), 64'(el));
  endtask

  initial begin
    #1;
    chk("reset_hi", 64'(hi), 64'h0);
    chk("reset_lo", 64'(lo), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    repeat (2) cyc();
    reset = 1'b1;

    issue(4'd1, 32'hFFFF_FFFE, 32'd3);
    chk("accept_after_reset", 64'(busy), 64'h1);
    wait_idle("mult_busy_len", 5);
    pin("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    issue(4'd2, 32'hFFFF_FFFF, 32'd2);
    wait_idle("multu_busy_len", 5);
    pin("multu", 32'h0000_0001, 32'hFFFF_FFFE);

    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle("div_busy_len", 10);
    pin("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    mt(1'b1, 1'b0, 32'h11);
    mt(1'b0, 1'b1, 32'h22);
    pin("mthi_mtlo", 32'h11, 32'h22);
    issue(4'd4, 32'd7, 32'd0);
    wait_idle("divu0_busy_len", 10);
    pin("divu_by_zero", 32'h11, 32'h22);

    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle("div_ovf_busy_len", 10);
    pin("div_overflow", 32'h0, 32'h8000_0000);

    issue(4'd4, 32'd7, 32'd2);
    wait_idle("divu_busy_len", 10);
    pin("divu", 32'd1, 32'd3);

    mt(1'b1, 1'b1, 32'h0000_ABCD);
    pin("mt_both", 32'h0000_ABCD, 32'h0000_ABCD);

    whi = 1'b1; wdata = 32'h999;
    issue(4'd1, 32'd2, 32'd3);
    whi = 1'b0;
    pin("start_beats_write_hold", 32'h0000_ABCD, 32'h0000_ABCD);
    wait_idle("start_write_busy_len", 5);
    pin("start_beats_write", 32'd0, 32'd6);

    start = 1'b1; mulop = 4'd5; wlo = 1'b1; wdata = 32'h77;
    cyc();
    start = 1'b0; mulop = 4'd0; wlo = 1'b0;
    chk("bad_op_busy", 64'(busy), 64'h0);
    pin("bad_op", 32'd0, 32'd6);

    issue(4'd1, 32'd5, 32'd7);
    hazmulti = 1'b1;
    cyc();
    cyc();
    start = 1'b1; mulop = 4'd2; a = 32'd9; b = 32'd9; wlo = 1'b1; wdata = 32'hDEAD;
    #1;
    chk("stall_busy", 64'(stall), 64'h1);
    cyc();
    start = 1'b0; mulop = 4'd0; wlo = 1'b0;
    wait_idle("no_restart_busy_len", 2);
    hazmulti = 1'b0;
    pin("no_restart", 32'd0, 32'd35);

    mt(1'b1, 1'b0, 32'h55);
    issue(4'd3, 32'd100, 32'd7);
    cyc();
    cyc();
    #2;
    reset = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'h0);
    pin("abort", 32'd0, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (15) cyc();
    chk("abort_late_busy", 64'(busy), 64'h0);
    pin("abort_no_commit", 32'd0, 32'd0);

    hazmulti = 1'b1;
    #1;
    chk("stall_idle", 64'(stall), 64'h0);
    start = 1'b1;
    #1;
    chk("stall_start", 64'(stall), 64'h1);
    start = 1'b0; hazmulti = 1'b0;
    repeat (2) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
